// File: rtl/axi_rw_bridge.sv
// axi_rw_bridge: arbitrates core fetch and data ports onto single-beat AXI4 transactions
module axi_rw_bridge #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] IF_ID  = '0,
    parameter logic [ID_W-1:0] MEM_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [63:0]     if_addr,
    input  logic [1:0]      if_size,
    output logic            if_ready,
    output logic [1:0]      if_resp,
    output logic [63:0]     if_data_read,
    input  logic            mem_valid,
    input  logic [1:0]      mem_req,
    input  logic [63:0]     mem_addr,
    input  logic [63:0]     mem_data_write,
    input  logic [1:0]      mem_size,
    output logic            mem_ready,
    output logic [1:0]      mem_resp,
    output logic [63:0]     mem_data_read,
    output logic            axi_ar_valid,
    input  logic            axi_ar_ready,
    output logic [63:0]     axi_ar_addr,
    output logic [ID_W-1:0] axi_ar_id,
    output logic [2:0]      axi_ar_size,
    output logic [7:0]      axi_ar_len,
    input  logic            axi_r_valid,
    output logic            axi_r_ready,
    input  logic [63:0]     axi_r_data,
    input  logic [1:0]      axi_r_resp,
    input  logic            axi_r_last,
    output logic            axi_aw_valid,
    input  logic            axi_aw_ready,
    output logic [63:0]     axi_aw_addr,
    output logic [ID_W-1:0] axi_aw_id,
    output logic [2:0]      axi_aw_size,
    output logic [7:0]      axi_aw_len,
    output logic            axi_w_valid,
    input  logic            axi_w_ready,
    output logic [63:0]     axi_w_data,
    output logic [7:0]      axi_w_strb,
    output logic            axi_w_last,
    input  logic            axi_b_valid,
    output logic            axi_b_ready,
    input  logic [1:0]      axi_b_resp
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
    state_t state, state_nxt;
    logic own_mem, aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic [63:0] addr_q;
    logic [1:0] size_q;
    logic accept, req_wr;
    logic [63:0] req_addr;
    logic [1:0] req_size;
    logic [7:0] req_mask;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic ar_valid_d, r_ready_d, aw_valid_d, w_valid_d, w_last_d, b_ready_d, if_ready_d, mem_ready_d;
    logic unused_r_last;

    assign unused_r_last = axi_r_last;
    assign accept   = state == IDLE && (mem_valid || if_valid);
    assign req_wr   = mem_valid && mem_req == 2'b01;
    assign req_addr = mem_valid ? mem_addr : if_addr;
    assign req_size = mem_valid ? mem_size : if_size;
    assign req_mask = req_size == 2'b00 ? 8'h01 : req_size == 2'b01 ? 8'h03 : req_size == 2'b10 ? 8'h0F : 8'hFF;
    assign ar_hs = axi_ar_valid && axi_ar_ready;
    assign r_hs  = axi_r_valid && axi_r_ready;
    assign aw_hs = axi_aw_valid && axi_aw_ready;
    assign w_hs  = axi_w_valid && axi_w_ready;
    assign b_hs  = axi_b_valid && axi_b_ready;
    assign axi_ar_addr = addr_q;
    assign axi_aw_addr = addr_q;
    assign axi_ar_size = {1'b0, size_q};
    assign axi_aw_size = {1'b0, size_q};
    assign axi_ar_id   = own_mem ? MEM_ID : IF_ID;
    assign axi_aw_id   = MEM_ID;
    assign axi_ar_len  = '0;
    assign axi_aw_len  = '0;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: one transaction at a time, data port wins arbitration
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_wr ? WR_REQ : RD_ADDR;
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = DONE;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // next values of the registered handshake outputs, taken from the upcoming state
    always_comb begin
        aw_done_nxt = state == WR_REQ && (aw_done || aw_hs);
        w_done_nxt  = state == WR_REQ && (w_done || w_hs);
        ar_valid_d  = state_nxt == RD_ADDR;
        r_ready_d   = state_nxt == RD_DATA;
        aw_valid_d  = state_nxt == WR_REQ && !aw_done_nxt;
        w_valid_d   = state_nxt == WR_REQ && !w_done_nxt;
        w_last_d    = state_nxt == WR_REQ;
        b_ready_d   = state_nxt == WR_RESP;
        if_ready_d  = state_nxt == DONE && !own_mem;
        mem_ready_d = state_nxt == DONE && own_mem;
    end

    // output flops, request latch at acceptance and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_w_last, axi_b_ready} <= '0;
            {if_ready, mem_ready, aw_done, w_done, own_mem} <= '0;
            {if_resp, mem_resp, if_data_read, mem_data_read} <= '0;
            {addr_q, size_q, axi_w_data, axi_w_strb} <= '0;
        end else begin
            axi_ar_valid <= ar_valid_d;
            axi_r_ready  <= r_ready_d;
            axi_aw_valid <= aw_valid_d;
            axi_w_valid  <= w_valid_d;
            axi_w_last   <= w_last_d;
            axi_b_ready  <= b_ready_d;
            if_ready     <= if_ready_d;
            mem_ready    <= mem_ready_d;
            aw_done      <= aw_done_nxt;
            w_done       <= w_done_nxt;
            if (accept) begin
                own_mem <= mem_valid;
                addr_q  <= req_addr;
                size_q  <= req_size;
            end
            if (accept && req_wr) begin
                axi_w_data <= mem_data_write << {mem_addr[2:0], 3'b000};
                axi_w_strb <= req_mask << mem_addr[2:0];
            end
            if (r_hs && own_mem) begin
                mem_data_read <= axi_r_data >> {addr_q[2:0], 3'b000};
                mem_resp      <= axi_r_resp;
            end
            if (r_hs && !own_mem) begin
                if_data_read <= axi_r_data >> {addr_q[2:0], 3'b000};
                if_resp      <= axi_r_resp;
            end
            if (b_hs) mem_resp <= axi_b_resp;
        end
    end
endmodule

// File: tb/tb_axi_rw_bridge.sv
// tb_axi_rw_bridge: randomized and directed checks of the AXI fetch/data bridge
module tb_axi_rw_bridge;
    localparam int ID_W = 4;
    localparam logic [ID_W-1:0] IF_ID = 4'd0;
    localparam logic [ID_W-1:0] MEM_ID = 4'd1;

    logic clk = 0, rst;
    logic if_valid, if_ready, mem_valid, mem_ready;
    logic [63:0] if_addr, if_data_read, mem_addr, mem_data_write, mem_data_read;
    logic [1:0] if_size, if_resp, mem_req, mem_size, mem_resp;
    logic axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready, axi_r_last;
    logic axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_w_last, axi_b_valid, axi_b_ready;
    logic [63:0] axi_ar_addr, axi_r_data, axi_aw_addr, axi_w_data;
    logic [ID_W-1:0] axi_ar_id, axi_aw_id;
    logic [2:0] axi_ar_size, axi_aw_size;
    logic [7:0] axi_ar_len, axi_aw_len, axi_w_strb;
    logic [1:0] axi_r_resp, axi_b_resp;

    int checks = 0, failures = 0;
    int cyc = 0, stab_err = 0, both_err = 0;
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, bready_cyc = 0;
    bit use_fixed = 0;
    logic [63:0] s_rdata = '0;
    logic [1:0] s_rresp = '0, s_bresp = '0;
    logic [63:0] l_ar_addr, l_aw_addr, l_w_data;
    logic [ID_W-1:0] l_ar_id, l_aw_id;
    logic [2:0] l_ar_size, l_aw_size;
    logic [7:0] l_ar_len, l_aw_len, l_w_strb;
    logic l_w_last;
    logic [ID_W-1:0] ar_ids[$];
    int ar_cycs[$];

    always #5 clk = ~clk;

    axi_rw_bridge dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_ready(if_ready),
        .if_resp(if_resp), .if_data_read(if_data_read),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_write(mem_data_write),
        .mem_size(mem_size), .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
        .axi_ar_id(axi_ar_id), .axi_ar_size(axi_ar_size), .axi_ar_len(axi_ar_len),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
        .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
        .axi_aw_id(axi_aw_id), .axi_aw_size(axi_aw_size), .axi_aw_len(axi_aw_len),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
        .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp)
    );

    // contents of the behavioural slave memory as a function of address
    function automatic logic [63:0] rword(input logic [63:0] a);
        return {a[31:0] * 32'h9E37_79B1, ~a[63:32]} ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    // AXI slave model: programmable ready/valid delays, logs every address/data handshake,
    // flags payload changes under valid and valids that linger after their handshake
    initial begin : slave
        int arw, rw, aww, ww, bw;
        bit rp, bp, awd, wd, ar_h, r_h, aw_h, w_h, b_h, arp, awp, wp;
        logic [63:0] ra, pa_ar, pa_aw, pw_d;
        logic [7:0] pw_s;
        logic [ID_W-1:0] pid_ar;
        logic [2:0] ps_ar;
        {arw, rw, aww, ww, bw} = '0;
        {rp, bp, awd, wd, ar_h, r_h, aw_h, w_h, b_h, arp, awp, wp} = '0;
        {ra, pa_ar, pa_aw, pw_d, pw_s, pid_ar, ps_ar} = '0;
        {axi_ar_ready, axi_r_valid, axi_r_last, axi_aw_ready, axi_w_ready, axi_b_valid} = '0;
        axi_r_data = '0; axi_r_resp = '0; axi_b_resp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                {rp, bp, awd, wd, ar_h, r_h, aw_h, w_h, b_h, arp, awp, wp} = '0;
                {arw, rw, aww, ww, bw} = '0;
                {axi_ar_ready, axi_r_valid, axi_r_last, axi_aw_ready, axi_w_ready, axi_b_valid} = '0;
                continue;
            end
            if (if_ready && mem_ready) both_err++;
            if (arp && !(axi_ar_valid && axi_ar_addr == pa_ar && axi_ar_id == pid_ar && axi_ar_size == ps_ar)) stab_err++;
            if (awp && !(axi_aw_valid && axi_aw_addr == pa_aw)) stab_err++;
            if (wp && !(axi_w_valid && axi_w_data == pw_d && axi_w_strb == pw_s)) stab_err++;
            if (r_h) axi_r_valid = 0;
            if (b_h) axi_b_valid = 0;
            if (ar_h) begin rp = 1; rw = 0; end
            if (aw_h) awd = 1;
            if (w_h) wd = 1;
            if (awd && axi_aw_valid) stab_err++;
            if (wd && axi_w_valid) stab_err++;
            if (awd && wd) begin awd = 0; wd = 0; bp = 1; bw = 0; end
            if (rp && !axi_r_valid) begin
                if (rw >= r_dly) begin
                    axi_r_valid = 1; axi_r_last = 1; axi_r_resp = s_rresp; rp = 0;
                    axi_r_data = use_fixed ? s_rdata : rword(ra);
                end else rw++;
            end
            if (bp && !axi_b_valid) begin
                if (bw >= b_dly) begin axi_b_valid = 1; axi_b_resp = s_bresp; bp = 0; end
                else bw++;
            end
            if (axi_ar_valid) begin axi_ar_ready = arw >= ar_dly; arw++; end else axi_ar_ready = 0;
            if (axi_aw_valid) begin axi_aw_ready = aww >= aw_dly; aww++; end else axi_aw_ready = 0;
            if (axi_w_valid) begin axi_w_ready = ww >= w_dly; ww++; end else axi_w_ready = 0;
            if (axi_b_ready && bready_cyc == 0) bready_cyc = cyc;
            ar_h = axi_ar_valid && axi_ar_ready;
            r_h  = axi_r_valid && axi_r_ready;
            aw_h = axi_aw_valid && axi_aw_ready;
            w_h  = axi_w_valid && axi_w_ready;
            b_h  = axi_b_valid && axi_b_ready;
            if (ar_h) begin
                ra = axi_ar_addr; l_ar_addr = axi_ar_addr; l_ar_id = axi_ar_id; l_ar_size = axi_ar_size;
                l_ar_len = axi_ar_len; ar_ids.push_back(axi_ar_id); ar_cycs.push_back(cyc); arw = 0;
            end
            if (aw_h) begin
                l_aw_addr = axi_aw_addr; l_aw_id = axi_aw_id; l_aw_size = axi_aw_size; l_aw_len = axi_aw_len;
                aw_hs_cyc = cyc; aww = 0;
            end
            if (w_h) begin
                l_w_data = axi_w_data; l_w_strb = axi_w_strb; l_w_last = axi_w_last; w_hs_cyc = cyc; ww = 0;
            end
            arp = axi_ar_valid && !ar_h; pa_ar = axi_ar_addr; pid_ar = axi_ar_id; ps_ar = axi_ar_size;
            awp = axi_aw_valid && !aw_h; pa_aw = axi_aw_addr;
            wp = axi_w_valid && !w_h; pw_d = axi_w_data; pw_s = axi_w_strb;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // drive one request on a port, wait (bounded) for its ready pulse and confirm the pulse is one cycle
    task automatic run_req(input bit is_mem, input logic [1:0] req, input logic [63:0] addr, input logic [1:0] size,
                           input logic [63:0] wd, input bit scramble,
                           output logic [63:0] rd, output logic [1:0] resp, output int lat);
        bit got = 0;
        if (is_mem) begin
            mem_valid = 1; mem_req = req; mem_addr = addr; mem_size = size; mem_data_write = wd;
        end else begin
            if_valid = 1; if_addr = addr; if_size = size;
        end
        lat = 0; rd = '0; resp = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick;
            lat++;
            if (is_mem ? mem_ready : if_ready) begin
                got = 1;
                rd = is_mem ? mem_data_read : if_data_read;
                resp = is_mem ? mem_resp : if_resp;
            end else if (scramble) begin
                if_addr = {$urandom, $urandom}; if_size = 2'($urandom);
                mem_addr = {$urandom, $urandom}; mem_size = 2'($urandom);
                mem_data_write = {$urandom, $urandom}; mem_req = 2'($urandom);
            end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL req_timeout got=no_ready exp=ready within 200 cycles"); end
        if (is_mem) mem_valid = 0; else if_valid = 0;
        tick;
        checks++;
        if ((is_mem ? mem_ready : if_ready) !== 1'b0) begin
            failures++; $display("FAIL ready_pulse_width got=1 exp=0 one cycle after pulse");
        end
    endtask

    task automatic test_reset;
        rst = 1;
        {if_valid, mem_valid} = '0; if_addr = '0; if_size = '0;
        mem_req = '0; mem_addr = '0; mem_size = '0; mem_data_write = '0;
        repeat (3) tick;
        checks++;
        if ({if_ready, mem_ready, axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, axi_w_last} !== 8'h00) begin
            failures++; $display("FAIL reset_ctl got=%b exp=00000000", {if_ready, mem_ready, axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, axi_w_last});
        end
        checks++;
        if ({if_resp, mem_resp} !== 4'h0) begin failures++; $display("FAIL reset_resp got=%h exp=0", {if_resp, mem_resp}); end
        checks++;
        if ({if_data_read, mem_data_read} !== 128'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {if_data_read, mem_data_read}); end
        checks++;
        if ({axi_ar_len, axi_aw_len} !== 16'h0) begin failures++; $display("FAIL reset_len got=%h exp=0", {axi_ar_len, axi_aw_len}); end
        rst = 0;
        tick;
    endtask

    task automatic test_fetch;
        logic [63:0] rd; logic [1:0] resp; int lat;
        use_fixed = 1; s_rdata = 64'h1234_5678_9ABC_DEF0; s_rresp = 2'b00;
        run_req(0, 2'b00, 64'h8000_0004, 2'b10, '0, 0, rd, resp, lat);
        use_fixed = 0;
        checks++; if (l_ar_addr !== 64'h8000_0004) begin failures++; $display("FAIL fetch_ar_addr got=%h exp=80000004", l_ar_addr); end
        checks++; if (l_ar_size !== 3'b010) begin failures++; $display("FAIL fetch_ar_size got=%b exp=010", l_ar_size); end
        checks++; if (l_ar_id !== IF_ID || l_ar_len !== 8'h00) begin failures++; $display("FAIL fetch_ar_id_len got=%h/%h exp=%h/00", l_ar_id, l_ar_len, IF_ID); end
        checks++; if (rd !== 64'h1234_5678) begin failures++; $display("FAIL fetch_data got=%h exp=12345678", rd); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL fetch_resp got=%b exp=00", resp); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
        checks++; if (if_data_read !== 64'h1234_5678) begin failures++; $display("FAIL fetch_data_hold got=%h exp=12345678", if_data_read); end
    endtask

    task automatic test_write;
        logic [63:0] rd; logic [1:0] resp; int lat;
        s_bresp = 2'b10;
        run_req(1, 2'b01, 64'h8000_0102, 2'b01, 64'hBEEF, 0, rd, resp, lat);
        checks++; if (l_w_strb !== 8'h0C) begin failures++; $display("FAIL write_strb got=%h exp=0c", l_w_strb); end
        checks++; if (l_w_data !== 64'h0000_0000_BEEF_0000) begin failures++; $display("FAIL write_data got=%h exp=00000000beef0000", l_w_data); end
        checks++; if (l_w_last !== 1'b1) begin failures++; $display("FAIL write_last got=%b exp=1", l_w_last); end
        checks++; if (l_aw_addr !== 64'h8000_0102 || l_aw_id !== MEM_ID || l_aw_size !== 3'b001 || l_aw_len !== 8'h00) begin
            failures++; $display("FAIL write_aw got=%h/%h/%b/%h exp=80000102/%h/001/00", l_aw_addr, l_aw_id, l_aw_size, l_aw_len, MEM_ID);
        end
        checks++; if (resp !== 2'b10) begin failures++; $display("FAIL write_bresp got=%b exp=10", resp); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", lat); end
        s_bresp = 2'b00;
    endtask

    task automatic test_contention;
        int n0, mcyc = 0;
        bit got_m = 0, got_i = 0;
        logic [63:0] ia = 64'h8000_1005, ma = 64'h8000_2003, id = '0, md = '0;
        s_rresp = 2'b00;
        n0 = ar_ids.size();
        if_valid = 1; if_addr = ia; if_size = 2'b11;
        mem_valid = 1; mem_req = 2'b00; mem_addr = ma; mem_size = 2'b10;
        for (int i = 0; i < 100 && !got_i; i++) begin
            tick;
            if (mem_ready) begin got_m = 1; mcyc = cyc; md = mem_data_read; mem_valid = 0; end
            if (if_ready) begin got_i = 1; id = if_data_read; if_valid = 0; end
        end
        tick;
        checks++; if (!(got_m && got_i)) begin failures++; $display("FAIL contention_done got=%b%b exp=11", got_m, got_i); end
        checks++;
        if (ar_ids.size() != n0 + 2) begin
            failures++; $display("FAIL contention_ar_count got=%0d exp=%0d", ar_ids.size() - n0, 2);
        end else begin
            checks++; if (ar_ids[n0] !== MEM_ID) begin failures++; $display("FAIL contention_first_id got=%h exp=%h", ar_ids[n0], MEM_ID); end
            checks++; if (ar_ids[n0+1] !== IF_ID) begin failures++; $display("FAIL contention_second_id got=%h exp=%h", ar_ids[n0+1], IF_ID); end
            checks++; if (ar_cycs[n0+1] != mcyc + 2) begin failures++; $display("FAIL contention_fetch_issue got=%0d exp=%0d", ar_cycs[n0+1], mcyc + 2); end
        end
        checks++; if (md !== rword(ma) >> 24) begin failures++; $display("FAIL contention_mem_data got=%h exp=%h", md, rword(ma) >> 24); end
        checks++; if (id !== rword(ia) >> 40) begin failures++; $display("FAIL contention_if_data got=%h exp=%h", id, rword(ia) >> 40); end
    endtask

    task automatic test_independent;
        logic [63:0] rd; logic [1:0] resp; int lat, s0;
        s0 = stab_err;
        aw_dly = 0; w_dly = 3; bready_cyc = 0;
        run_req(1, 2'b01, 64'h8000_0040, 2'b11, 64'h1122_3344_5566_7788, 0, rd, resp, lat);
        checks++; if (w_hs_cyc - aw_hs_cyc != 3) begin failures++; $display("FAIL indep_w_delay got=%0d exp=3", w_hs_cyc - aw_hs_cyc); end
        checks++; if (bready_cyc <= w_hs_cyc) begin failures++; $display("FAIL indep_bready_early got=%0d exp>%0d", bready_cyc, w_hs_cyc); end
        checks++; if (stab_err != s0) begin failures++; $display("FAIL indep_valid_drop got=%0d exp=%0d", stab_err, s0); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL indep_latency got=%0d exp=6", lat); end
        w_dly = 0; bready_cyc = 0;
        run_req(1, 2'b01, 64'h8000_0047, 2'b00, 64'hA5, 0, rd, resp, lat);
        checks++; if (aw_hs_cyc != w_hs_cyc) begin failures++; $display("FAIL same_cycle_hs got=%0d exp=%0d", w_hs_cyc, aw_hs_cyc); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL same_cycle_latency got=%0d exp=3", lat); end
        checks++; if (l_w_strb !== 8'h80 || l_w_data !== 64'hA500_0000_0000_0000) begin
            failures++; $display("FAIL same_cycle_w got=%h/%h exp=80/a500000000000000", l_w_strb, l_w_data);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] rd; logic [1:0] resp; int lat, s0;
        logic [63:0] a = 64'h8000_3006;
        s0 = stab_err; ar_dly = 5;
        run_req(0, 2'b00, a, 2'b01, '0, 1, rd, resp, lat);
        ar_dly = 0;
        checks++; if (l_ar_addr !== a) begin failures++; $display("FAIL bp_ar_addr got=%h exp=%h", l_ar_addr, a); end
        checks++; if (stab_err != s0) begin failures++; $display("FAIL bp_ar_stable got=%0d exp=%0d", stab_err, s0); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", lat); end
        checks++; if (rd !== rword(a) >> 48) begin failures++; $display("FAIL bp_data got=%h exp=%h", rd, rword(a) >> 48); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] rd; logic [1:0] resp; int lat;
        logic [63:0] a = 64'h8000_4001;
        r_dly = 20; if_valid = 1; if_addr = a; if_size = 2'b11;
        for (int i = 0; i < 50 && !axi_r_ready; i++) tick;
        checks++; if (axi_r_ready !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%b exp=1", axi_r_ready); end
        rst = 1;
        #1;
        checks++;
        if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_ready, mem_ready} !== 7'h0) begin
            failures++; $display("FAIL rstmid_clear got=%b exp=0000000", {axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_ready, mem_ready});
        end
        if_valid = 0;
        repeat (2) tick;
        rst = 0; r_dly = 0;
        tick;
        run_req(0, 2'b00, a, 2'b11, '0, 0, rd, resp, lat);
        checks++; if (rd !== rword(a) >> 8) begin failures++; $display("FAIL rstmid_after_data got=%h exp=%h", rd, rword(a) >> 8); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_random;
        logic [63:0] rd, addr, wd, exp_d; logic [1:0] resp, size, req; logic [15:0] sm;
        int lat, kind, n0, off, nb, r;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            addr = {$urandom, $urandom}; wd = {$urandom, $urandom}; size = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 2);
            req = kind == 2 ? 2'b01 : r == 0 ? 2'b00 : r == 1 ? 2'b10 : 2'b11;
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
            w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            s_rresp = 2'($urandom); s_bresp = 2'($urandom);
            off = int'(addr % 8); nb = 1 << size;
            n0 = ar_ids.size();
            run_req(kind != 0, req, addr, size, wd, 1, rd, resp, lat);
            if (kind != 2) begin
                exp_d = rword(addr) >> (off * 8);
                checks++; if (ar_ids.size() != n0 + 1) begin failures++; $display("FAIL rnd%0d_ar_count got=%0d exp=1", t, ar_ids.size() - n0); end
                checks++; if (l_ar_addr !== addr) begin failures++; $display("FAIL rnd%0d_ar_addr got=%h exp=%h", t, l_ar_addr, addr); end
                checks++; if (l_ar_size !== {1'b0, size}) begin failures++; $display("FAIL rnd%0d_ar_size got=%b exp=0%b", t, l_ar_size, size); end
                checks++; if (l_ar_id !== (kind == 1 ? MEM_ID : IF_ID)) begin failures++; $display("FAIL rnd%0d_ar_id got=%h exp=%0d", t, l_ar_id, kind == 1); end
                checks++; if (rd !== exp_d) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, rd, exp_d); end
                checks++; if (resp !== s_rresp) begin failures++; $display("FAIL rnd%0d_rresp got=%b exp=%b", t, resp, s_rresp); end
            end else begin
                exp_d = wd << (off * 8);
                sm = ((16'd1 << nb) - 16'd1) << off;
                checks++; if (ar_ids.size() != n0) begin failures++; $display("FAIL rnd%0d_spurious_ar got=%0d exp=0", t, ar_ids.size() - n0); end
                checks++; if (l_aw_addr !== addr || l_aw_id !== MEM_ID || l_aw_size !== {1'b0, size}) begin
                    failures++; $display("FAIL rnd%0d_aw got=%h/%h/%b exp=%h/%h/0%b", t, l_aw_addr, l_aw_id, l_aw_size, addr, MEM_ID, size);
                end
                checks++; if (l_w_data !== exp_d) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", t, l_w_data, exp_d); end
                checks++; if (l_w_strb !== sm[7:0]) begin failures++; $display("FAIL rnd%0d_wstrb got=%h exp=%h", t, l_w_strb, sm[7:0]); end
                checks++; if (resp !== s_bresp) begin failures++; $display("FAIL rnd%0d_bresp got=%b exp=%b", t, resp, s_bresp); end
            end
        end
        {ar_dly, r_dly, aw_dly, w_dly, b_dly} = '0;
        checks++; if (stab_err != 0) begin failures++; $display("FAIL protocol_stability got=%0d exp=0", stab_err); end
        checks++; if (both_err != 0) begin failures++; $display("FAIL both_ready got=%0d exp=0", both_err); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_write;
        test_contention;
        test_independent;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
